// File: rtl/rgb_mixer_pkg.sv
// Shared types and the saturating step helper for the RGB mixer update path.
package rgb_mixer_pkg;

  localparam int NUM_CH = 3;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  // Values are carried zero-extended to 32 bits so one helper serves any WIDTH.
  function automatic logic [31:0] sat_step(input logic [31:0] val, input dir_t dir,
                                           input logic [31:0] step, input logic [31:0] maxv);
    logic [32:0] sum;
    if (dir == DIR_UP) begin
      sum = {1'b0, val} + {1'b0, step};
      return (sum > {1'b0, maxv}) ? maxv : sum[31:0];
    end
    return (val < step) ? 32'd0 : val - step;
  endfunction

endpackage

// File: rtl/rgb_update_sequencer_rr_arbiter3.sv
// Three-way round-robin grant: first pending request at or after ptr, modulo 3.
module rr_arbiter3
  import rgb_mixer_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           ptr,
  output logic              grant_valid,
  output ch_idx_t           grant_idx
);

  ch_idx_t w_idx;

  function automatic ch_idx_t add_mod3(input ch_idx_t a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Scan farthest-first so the nearest pending channel wins the last assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = add_mod3(ptr, k[1:0]);
      if (req[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/rgb_update_sequencer.sv
// Latches encoder step requests, applies them one per cycle to shadow duties and commits
// shadows to the PWM duties at frame wrap. Define STEP_ACCEL_EN for repeat-step acceleration.
module rgb_update_sequencer
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_FAST = 4,
  parameter int ACCEL_WIN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] step_valid,
  input  logic [NUM_CH-1:0] step_dir,
  output logic [WIDTH-1:0]  duty0,
  output logic [WIDTH-1:0]  duty1,
  output logic [WIDTH-1:0]  duty2,
  output logic [WIDTH-1:0]  frame_cnt,
  output logic              frame_start,
  output logic              busy,
  output logic              drop_err
);

  localparam logic [31:0] MAXV = 32'((64'd1 << WIDTH) - 64'd1);

  logic [WIDTH-1:0]  r_shadow [NUM_CH];
  logic [WIDTH-1:0]  r_duty   [NUM_CH];
  logic [WIDTH-1:0]  r_frame;
  logic [NUM_CH-1:0] r_pend, r_pdir;
  logic [NUM_CH-1:0] w_pend_nxt, w_pdir_nxt;
  ch_idx_t           r_ptr, w_gidx;
  logic              w_gvld, r_drop, w_drop_set;
  logic [31:0]       w_step, w_sum;
  logic [WIDTH-1:0]  w_shadow_nxt;

  rr_arbiter3 u_arb (
    .req        (r_pend),
    .ptr        (r_ptr),
    .grant_valid(w_gvld),
    .grant_idx  (w_gidx)
  );

`ifdef STEP_ACCEL_EN
  localparam int CW = $clog2(ACCEL_WIN + 1);
  localparam logic [CW-1:0] ACC_MAX = CW'(ACCEL_WIN);

  logic [CW-1:0]     r_acnt [NUM_CH];
  logic [NUM_CH-1:0] r_ldir, r_lvld;

  // A fast step needs a previous granted step on this channel to compare against.
  always_comb begin
    w_step = 32'd1;
    if (w_gvld && r_lvld[w_gidx] && (r_ldir[w_gidx] == r_pdir[w_gidx]) &&
        (r_acnt[w_gidx] < ACC_MAX))
      w_step = 32'(STEP_FAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ldir <= '0;
      r_lvld <= '0;
      for (int i = 0; i < NUM_CH; i++) r_acnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_gvld && (w_gidx == ch_idx_t'(i))) begin
          r_acnt[i] <= '0;
          r_ldir[i] <= r_pdir[i];
          r_lvld[i] <= 1'b1;
        end else if (r_acnt[i] != ACC_MAX) begin
          r_acnt[i] <= r_acnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_step = 32'd1;
`endif

  assign w_sum        = sat_step(32'(r_shadow[w_gidx]), dir_t'(r_pdir[w_gidx]), w_step, MAXV);
  assign w_shadow_nxt = w_sum[WIDTH-1:0];

  // A pulse on the channel being granted this cycle replaces the consumed request.
  always_comb begin
    w_pend_nxt = r_pend;
    w_pdir_nxt = r_pdir;
    w_drop_set = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gvld && (w_gidx == ch_idx_t'(i))) w_pend_nxt[i] = 1'b0;
      if (step_valid[i]) begin
        if (r_pend[i] && !(w_gvld && (w_gidx == ch_idx_t'(i)))) begin
          if (step_dir[i] == r_pdir[i]) w_drop_set    = 1'b1;
          else                          w_pend_nxt[i] = 1'b0;
        end else begin
          w_pend_nxt[i] = 1'b1;
          w_pdir_nxt[i] = step_dir[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame <= '0;
      r_pend  <= '0;
      r_pdir  <= '0;
      r_ptr   <= '0;
      r_drop  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_duty[i]   <= '0;
      end
    end else begin
      r_frame <= r_frame + 1'b1;
      r_pend  <= w_pend_nxt;
      r_pdir  <= w_pdir_nxt;
      if (w_drop_set) r_drop <= 1'b1;
      if (w_gvld) begin
        r_shadow[w_gidx] <= w_shadow_nxt;
        r_ptr            <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
      end
      // Commit sees the pre-update shadow; a same-edge grant waits for the next wrap.
      if (&r_frame) r_duty <= r_shadow;
    end
  end

  assign duty0       = r_duty[0];
  assign duty1       = r_duty[1];
  assign duty2       = r_duty[2];
  assign frame_cnt   = r_frame;
  assign frame_start = (r_frame == '0);
  assign busy        = |r_pend;
  assign drop_err    = r_drop;

endmodule

// File: tb/tb_rgb_update_sequencer.sv
// Randomized and directed bench for rgb_update_sequencer against a cycle-level reference model.
module tb_rgb_update_sequencer;

  localparam int WIDTH     = 8;
  localparam int STEP_FAST = 4;
  localparam int ACCEL_WIN = 64;
  localparam int MAXV      = (1 << WIDTH) - 1;
`ifdef STEP_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       step_valid = '0;
  logic [2:0]       step_dir = '0;
  logic [WIDTH-1:0] duty0, duty1, duty2, frame_cnt;
  logic             frame_start, busy, drop_err;

  rgb_update_sequencer #(.WIDTH(WIDTH), .STEP_FAST(STEP_FAST), .ACCEL_WIN(ACCEL_WIN)) dut (
    .clk(clk), .reset(reset), .step_valid(step_valid), .step_dir(step_dir),
    .duty0(duty0), .duty1(duty1), .duty2(duty2), .frame_cnt(frame_cnt),
    .frame_start(frame_start), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the design should hold after the most recent rising edge.
  int m_pend [3];
  int m_dir  [3];
  int m_sh   [3];
  int m_duty [3];
  int m_has  [3];
  int m_ldir [3];
  int m_last [3];
  int m_frame, m_ptr, m_drop, m_cyc;
  bit m_known = 1'b0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [2:0] sv, input logic [2:0] sd);
    int g, c, st, nv;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0; m_dir[i] = 0; m_sh[i] = 0; m_duty[i] = 0;
        m_has[i] = 0;  m_ldir[i] = 0; m_last[i] = 0;
      end
      m_frame = 0; m_ptr = 0; m_drop = 0; m_cyc = 0; m_known = 1'b1;
      return;
    end
    m_cyc++;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      c = (m_ptr + k) % 3;
      if (g < 0 && m_pend[c] != 0) g = c;
    end
    if (m_frame == MAXV)
      for (int i = 0; i < 3; i++) m_duty[i] = m_sh[i];
    if (g >= 0) begin
      st = 1;
      if (ACCEL && m_has[g] != 0 && m_ldir[g] == m_dir[g] && (m_cyc - m_last[g]) <= ACCEL_WIN)
        st = STEP_FAST;
      nv = (m_dir[g] != 0) ? m_sh[g] + st : m_sh[g] - st;
      if (nv > MAXV) nv = MAXV;
      if (nv < 0) nv = 0;
      m_sh[g] = nv;
      m_has[g] = 1; m_ldir[g] = m_dir[g]; m_last[g] = m_cyc;
      m_ptr = (g + 1) % 3;
    end
    for (int i = 0; i < 3; i++) begin
      if (sv[i]) begin
        if (m_pend[i] != 0 && g != i) begin
          if (int'(sd[i]) == m_dir[i]) m_drop = 1;
          else m_pend[i] = 0;
        end else begin
          m_pend[i] = 1;
          m_dir[i] = int'(sd[i]);
        end
      end else if (g == i) begin
        m_pend[i] = 0;
      end
    end
    m_frame = (m_frame + 1) % (MAXV + 1);
  endtask

  task automatic compare_outputs();
    check_eq("duty0", int'(duty0), m_duty[0]);
    check_eq("duty1", int'(duty1), m_duty[1]);
    check_eq("duty2", int'(duty2), m_duty[2]);
    check_eq("frame_cnt", int'(frame_cnt), m_frame);
    check_eq("frame_start", int'(frame_start), (m_frame == 0) ? 1 : 0);
    check_eq("busy", int'(busy), (m_pend[0] + m_pend[1] + m_pend[2] != 0) ? 1 : 0);
    check_eq("drop_err", int'(drop_err), m_drop);
  endtask

  // One clock: check the state left by the last edge, then drive and predict the next edge.
  task automatic cycle(input logic rst, input logic [2:0] sv, input logic [2:0] sd);
    @(negedge clk);
    if (m_known) compare_outputs();
    reset = rst;
    step_valid = sv;
    step_dir = sd;
    model_step(rst, sv, sd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'b000, 3'b000);
  endtask

  initial begin
    logic [2:0] sv, sd;
    int up_pct;

    // Single up pulse on ch0: duty0 only moves at the frame wrap.
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b000, 3'b000);
    check_eq("rst_frame_start", int'(frame_start), 1);
    check_eq("rst_busy", int'(busy), 0);
    cycle(1'b0, 3'b001, 3'b001);
    idle(10);
    check_eq("t1_duty0_pre", int'(duty0), 0);
    idle(260);
    check_eq("t1_duty0_post", int'(duty0), 1);

    // All three channels at once: busy held through three grants.
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b111, 3'b111);
    cycle(1'b0, 3'b000, 3'b000);
    check_eq("t2_busy_n1", int'(busy), 1);
    cycle(1'b0, 3'b000, 3'b000);
    check_eq("t2_busy_n2", int'(busy), 1);
    cycle(1'b0, 3'b000, 3'b000);
    check_eq("t2_busy_n3", int'(busy), 1);
    cycle(1'b0, 3'b000, 3'b000);
    check_eq("t2_busy_n4", int'(busy), 0);

    // Saturation: ch1 pushed past full scale, ch2 pushed below zero.
    cycle(1'b1, 3'b000, 3'b000);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 3'b110, 3'b010);
      cycle(1'b0, 3'b000, 3'b000);
    end
    idle(300);
    check_eq("t3_duty1_sat", int'(duty1), MAXV);
    check_eq("t3_duty2_sat", int'(duty2), 0);
    check_eq("t3_drop", int'(drop_err), 0);

    // Same-direction repeat while ch0 is blocked: lost step, sticky error.
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b110, 3'b110);
    cycle(1'b0, 3'b001, 3'b001);
    cycle(1'b0, 3'b001, 3'b001);
    idle(300);
    check_eq("t4_duty0_drop", int'(duty0), 1);
    check_eq("t4_drop_set", int'(drop_err), 1);

    // Opposite-direction repeat: the two cancel.
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b110, 3'b110);
    cycle(1'b0, 3'b001, 3'b001);
    cycle(1'b0, 3'b001, 3'b000);
    idle(300);
    check_eq("t4_duty0_cancel", int'(duty0), 0);
    check_eq("t4_drop_clear", int'(drop_err), 0);

    // Grant to ch1 on the wrap edge: pulse two edges before the wrap.
    cycle(1'b1, 3'b000, 3'b000);
    idle(MAXV - 1);
    cycle(1'b0, 3'b010, 3'b010);
    idle(3);
    check_eq("t5_duty1_hold", int'(duty1), 0);
    idle(260);
    check_eq("t5_duty1_next", int'(duty1), 1);

    // Repeat pulses close together and far apart, then reset mid-burst.
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b001, 3'b001);
    idle(9);
    cycle(1'b0, 3'b001, 3'b001);
    idle(100);
    cycle(1'b0, 3'b001, 3'b001);
    idle(300);
    check_eq("t6_duty0", int'(duty0), ACCEL ? 6 : 3);
    cycle(1'b0, 3'b111, 3'b101);
    cycle(1'b0, 3'b011, 3'b011);
    cycle(1'b1, 3'b111, 3'b111);
    cycle(1'b0, 3'b000, 3'b000);
    check_eq("t6_rst_duty0", int'(duty0), 0);
    check_eq("t6_rst_busy", int'(busy), 0);

    // Randomized traffic with directional bias phases to reach both rails.
    for (int n = 0; n < 6000; n++) begin
      sv = '0;
      sd = '0;
      case (n / 1000)
        1, 3:    up_pct = 90;
        2, 4:    up_pct = 10;
        default: up_pct = 50;
      endcase
      for (int i = 0; i < 3; i++) begin
        sv[i] = ($urandom_range(0, 99) < 35);
        sd[i] = ($urandom_range(0, 99) < up_pct);
      end
      cycle(($urandom_range(0, 2499) == 0), sv, sd);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
